systolic_input_feeder: RTL and testbench
========================================

SYSTOLIC_INPUT_FEEDER -- requirements
Module: systolic_input_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 8, the number of PE rows fed.
REQ-002 SHALL have parameter DATA_W, default 16, the width of each activation and weight element.
REQ-003 SHALL have parameter K, default 4, the number of elements streamed per row.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: global advance enable; 0 stalls the block.
REQ-007 SHALL have port wr_en, input, 1 bit: buffer write strobe.
REQ-008 SHALL have port wr_addr, input, clog2(ROWS*K) bits: buffer entry index; row r, element j is at r*K+j.
REQ-009 SHALL have port wr_act, input, DATA_W bits: activation write data.
REQ-010 SHALL have port wr_wgt, input, DATA_W bits: weight write data.
REQ-011 SHALL have port start, input, 1 bit: stream request.
REQ-012 SHALL have port cluster_done, input, 1 bit: last-row done returned by the PE cluster.
REQ-013 SHALL have port activations, output, ROWS*DATA_W bits: skewed activation lanes; lane r is [r*DATA_W +: DATA_W].
REQ-014 SHALL have port weights, output, ROWS*DATA_W bits: skewed weight lanes, same lane packing as activations.
REQ-015 SHALL have port done, output, ROWS bits: per-lane end-of-stream flags.
REQ-016 SHALL have port busy, output, 1 bit: high while in RUN or WAIT.
REQ-017 SHALL have port finish, output, 1 bit: one-cycle completion pulse.

Function
REQ-018 SHALL hold two internal buffers (activation and weight) of ROWS*K entries each.
REQ-019 SHALL write both buffers at wr_addr when wr_en=1 and state is IDLE; SHALL ignore writes in any other state.
REQ-020 SHALL implement the state machine IDLE -> RUN -> WAIT -> IDLE.
REQ-021 SHALL leave IDLE for RUN on start=1 with en=1; the cycle on which start is sampled is t0.
REQ-022 SHALL ignore start when the state is not IDLE.
REQ-023 SHALL, on entry to RUN, clear done, then drive lane r with buffer entry r*K+j on output cycle t0+1+r+j, for j=0..K-1.
REQ-024 SHALL drive lane r to zero on every other cycle.
REQ-025 SHALL, for lane r at cycle t0+1+r+K, drive zero data and set done[r]=1; done[r] then holds 1 until the next accepted start or rst.
REQ-026 SHALL maintain one counter per lane, wide enough to count 0..K+1, and gate lane r+1 on lane r's counter being nonzero, so that the one-cycle skew per row is preserved.
REQ-027 SHALL move RUN -> WAIT on the cycle after done[ROWS-1] is set (t0+ROWS+K).
REQ-028 SHALL, in WAIT, pulse finish=1 for exactly one cycle on the first cycle cluster_done=1 is sampled, and move to IDLE on that same cycle.
REQ-029 SHALL, when en=0, freeze state, counters and buffer reads, hold every output at its current value, suppress finish and not sample start; rst still takes effect.
REQ-030 SHALL, when wr_en and start coincide in IDLE, commit the write first so that the streamed data includes it.
REQ-031 SHALL treat buffer contents as opaque bits, with no arithmetic on the data.
REQ-032 SHALL, for K=1, emit a single element per lane followed by its done cycle.

Reset
REQ-033 SHALL, when rst=1 at a rising edge, set state IDLE, all counters 0, activations=0, weights=0, done=0, busy=0 and finish=0.
REQ-034 SHALL leave buffer contents unchanged on rst.
REQ-035 SHALL, on rst asserted mid-RUN or mid-WAIT, abort the stream and drive zero outputs from the next cycle.
REQ-036 SHALL accept start one cycle after rst is released.

Verification
REQ-037 SHALL verify the basic skewed stream: load entries 0..31 with act=0x0100+i and wgt=0x0200+i, then pulse start at t0 -> lane0 shows 0x0100..0x0103 at t0+1..t0+4 with done[0]=1 at t0+5; lane7 shows 0x011C..0x011F at t0+8..t0+11 with done[7]=1 at t0+12; all other lane cycles are 0.
REQ-038 SHALL verify completion handshake: after REQ-037, hold cluster_done=0 for 5 cycles then drive it to 1 -> busy stays 1, finish pulses for exactly one cycle, state returns to IDLE, and busy=0 on the next cycle.
REQ-039 SHALL verify stall: drop en at t0+3 for 3 cycles -> all outputs hold; the sequence resumes unaltered and each later timestamp shifts by +3.
REQ-040 SHALL verify ignored requests: a second start and a wr_en to entry 5 during RUN -> no restart, and entry 5 is unchanged on the next stream.
REQ-041 SHALL verify reset mid-operation: assert rst at t0+6 -> the next cycle shows all outputs 0, done=0 and busy=0; a new start then replays the buffer from lane0, element 0.
REQ-042 SHALL verify coincident write and start: wr_en to entry 0 with act=0xBEEF at the same cycle as start -> lane0 emits 0xBEEF at t0+1.

Source files
------------

// File: rtl/systolic_input_feeder.sv
// rtl/systolic_input_feeder.sv - skewed activation/weight feeder for a systolic PE array
// Buffers ROWS*K element pairs and streams them out with a one-cycle skew per row.
module systolic_input_feeder #(
  parameter int ROWS   = 8,
  parameter int DATA_W = 16,
  parameter int K      = 4,
  localparam int AW    = (ROWS * K > 1) ? $clog2(ROWS * K) : 1,
  localparam int CW    = $clog2(K + 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_act,
  input  logic [DATA_W-1:0]        wr_wgt,
  input  logic                     start,
  input  logic                     cluster_done,
  output logic [ROWS*DATA_W-1:0]   activations,
  output logic [ROWS*DATA_W-1:0]   weights,
  output logic [ROWS-1:0]          done,
  output logic                     busy,
  output logic                     finish
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]             r_state;
  logic [DATA_W-1:0]      r_act_buf [ROWS*K];
  logic [DATA_W-1:0]      r_wgt_buf [ROWS*K];
  logic [CW-1:0]          r_cnt     [ROWS];
  logic [ROWS*DATA_W-1:0] r_act;
  logic [ROWS*DATA_W-1:0] r_wgt;
  logic [ROWS-1:0]        r_done;
  logic [ROWS-1:0]        w_go;
  logic [AW-1:0]          w_idx     [ROWS];

  // A lane advances once its upstream neighbour has started, which creates the skew.
  always_comb begin
    w_go[0] = (r_cnt[0] <= CW'(K));
    for (int r = 1; r < ROWS; r++) begin
      w_go[r] = (r_cnt[r] <= CW'(K)) && (r_cnt[r-1] != '0);
    end
    for (int r = 0; r < ROWS; r++) begin
      w_idx[r] = AW'(r * K) + AW'(r_cnt[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (r_state == S_IDLE)) begin
      r_act_buf[wr_addr] <= wr_act;
      r_wgt_buf[wr_addr] <= wr_wgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_act   <= '0;
      r_wgt   <= '0;
      r_done  <= '0;
      for (int r = 0; r < ROWS; r++) r_cnt[r] <= '0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_act   <= '0;
            r_wgt   <= '0;
            r_done  <= '0;
            for (int r = 0; r < ROWS; r++) r_cnt[r] <= '0;
          end
        end
        S_RUN: begin
          for (int r = 0; r < ROWS; r++) begin
            r_act[r*DATA_W +: DATA_W] <= '0;
            r_wgt[r*DATA_W +: DATA_W] <= '0;
            if (w_go[r]) begin
              r_cnt[r] <= r_cnt[r] + CW'(1);
              if (r_cnt[r] < CW'(K)) begin
                r_act[r*DATA_W +: DATA_W] <= r_act_buf[w_idx[r]];
                r_wgt[r*DATA_W +: DATA_W] <= r_wgt_buf[w_idx[r]];
              end else begin
                r_done[r] <= 1'b1;
              end
            end
          end
          if (w_go[ROWS-1] && (r_cnt[ROWS-1] == CW'(K))) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (cluster_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign activations = r_act;
  assign weights     = r_wgt;
  assign done        = r_done;
  assign busy        = (r_state != S_IDLE);
  assign finish      = (r_state == S_WAIT) && cluster_done && en && !rst;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb/tb_systolic_input_feeder.sv - randomized self-checking bench for systolic_input_feeder
module tb_systolic_input_feeder;
  localparam int ROWS = 8;
  localparam int DW   = 16;
  localparam int K    = 4;
  localparam int N    = ROWS * K;
  localparam int AW   = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, wr_en = 1'b0, start = 1'b0, cluster_done = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_act = '0, wr_wgt = '0;
  logic [ROWS*DW-1:0] activations, weights;
  logic [ROWS-1:0] done;
  logic busy, finish;

  logic k1_wr_en = 1'b0, k1_start = 1'b0, k1_cd = 1'b0;
  logic [0:0] k1_wr_addr = '0;
  logic [7:0] k1_wr_act = '0, k1_wr_wgt = '0;
  logic [15:0] k1_act, k1_wgt;
  logic [1:0] k1_done;
  logic k1_busy, k1_finish;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] m_act [N];
  logic [DW-1:0] m_wgt [N];

  systolic_input_feeder #(.ROWS(ROWS), .DATA_W(DW), .K(K)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_act(wr_act), .wr_wgt(wr_wgt), .start(start), .cluster_done(cluster_done),
    .activations(activations), .weights(weights), .done(done), .busy(busy), .finish(finish)
  );

  systolic_input_feeder #(.ROWS(2), .DATA_W(8), .K(1)) dut_k1 (
    .clk(clk), .rst(rst), .en(en), .wr_en(k1_wr_en), .wr_addr(k1_wr_addr),
    .wr_act(k1_wr_act), .wr_wgt(k1_wr_wgt), .start(k1_start), .cluster_done(k1_cd),
    .activations(k1_act), .weights(k1_wgt), .done(k1_done), .busy(k1_busy), .finish(k1_finish)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected lane picture k enabled edges after start: lane r shows element k-r-1, then done.
  function automatic void model(input int k, output logic [ROWS*DW-1:0] ea,
                                output logic [ROWS*DW-1:0] ew, output logic [ROWS-1:0] ed);
    ea = '0; ew = '0; ed = '0;
    for (int r = 0; r < ROWS; r++) begin
      int j;
      j = k - r - 1;
      if (j >= 0 && j < K) begin
        ea[r*DW +: DW] = m_act[r*K + j];
        ew[r*DW +: DW] = m_wgt[r*K + j];
      end
      ed[r] = (j >= K);
    end
  endfunction

  task automatic load(input bit pattern);
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i);
      wr_act = pattern ? DW'(16'h0100 + i) : DW'($urandom);
      wr_wgt = pattern ? DW'(16'h0200 + i) : DW'($urandom);
      m_act[i] = wr_act; m_wgt[i] = wr_wgt;
      tick;
    end
    wr_en = 1'b0;
  endtask

  task automatic run_stream(input string tag, input int stall_at, input int stall_len,
                            input bit stray, input int rst_at);
    int k;
    logic [ROWS*DW-1:0] ea, ew;
    logic [ROWS-1:0] ed;
    k = 0;
    en = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; wr_en = 1'b0;
    for (int e = 0; e <= ROWS + K + stall_len + 2; e++) begin
      if (e > 0) begin
        en = !(e >= stall_at && e < stall_at + stall_len);
        if (stray && e == 3) begin
          start = 1'b1; wr_en = 1'b1; wr_addr = AW'(5);
          wr_act = DW'($urandom); wr_wgt = DW'($urandom);
        end
        if (e == rst_at) rst = 1'b1;
        tick;
        start = 1'b0; wr_en = 1'b0;
        if (e == rst_at) begin
          rst = 1'b0;
          n_cmp++;
          if (activations !== '0 || weights !== '0 || done !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s rst_abort: act=%h wgt=%h done=%b busy=%b want all 0",
                     tag, activations, weights, done, busy);
          end
          en = 1'b1;
          return;
        end
        if (en) k++;
      end
      model(k, ea, ew, ed);
      n_cmp++;
      if (activations !== ea) begin
        n_bad++;
        $display("FAIL %s act k=%0d: got %h want %h", tag, k, activations, ea);
      end
      n_cmp++;
      if (weights !== ew) begin
        n_bad++;
        $display("FAIL %s wgt k=%0d: got %h want %h", tag, k, weights, ew);
      end
      n_cmp++;
      if (done !== ed) begin
        n_bad++;
        $display("FAIL %s done k=%0d: got %b want %b", tag, k, done, ed);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy k=%0d: got %b want 1", tag, k, busy);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0;
    tick; tick;
    n_cmp++;
    if (activations !== '0 || weights !== '0 || done !== '0 || busy !== 1'b0 || finish !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: act=%h wgt=%h done=%b busy=%b finish=%b want all 0",
               activations, weights, done, busy, finish);
    end
    rst = 1'b0; en = 1'b1;
    tick;
  endtask

  task automatic test_completion(input string tag);
    cluster_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++;
      if (busy !== 1'b1 || finish !== 1'b0) begin
        n_bad++;
        $display("FAIL %s wait_hold: busy=%b finish=%b want 1/0", tag, busy, finish);
      end
    end
    en = 1'b0; cluster_done = 1'b1;
    #1;
    n_cmp++;
    if (finish !== 1'b0) begin
      n_bad++;
      $display("FAIL %s finish_stalled: got %b want 0", tag, finish);
    end
    tick;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_stalled: got %b want 1", tag, busy);
    end
    en = 1'b1;
    #1;
    n_cmp++;
    if (finish !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s finish_pulse: finish=%b busy=%b want 1/1", tag, finish, busy);
    end
    tick;
    n_cmp++;
    if (finish !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s back_idle: finish=%b busy=%b want 0/0", tag, finish, busy);
    end
    cluster_done = 1'b0;
    tick;
  endtask

  task automatic test_basic_stream;
    load(1'b1);
    run_stream("basic", 0, 0, 1'b0, 0);
    test_completion("basic");
  endtask

  task automatic test_stall;
    load(1'b0);
    run_stream("stall", 3, 3, 1'b0, 0);
    test_completion("stall");
  endtask

  task automatic test_ignored_requests;
    run_stream("stray", 0, 0, 1'b1, 0);
    test_completion("stray");
    run_stream("after_stray", 0, 0, 1'b0, 0);
    test_completion("after_stray");
  endtask

  task automatic test_reset_mid;
    run_stream("rst_mid", 0, 0, 1'b0, 6);
    run_stream("replay", 0, 0, 1'b0, 0);
    test_completion("replay");
  endtask

  task automatic test_coincident_write;
    wr_en = 1'b1; wr_addr = '0; wr_act = 16'hBEEF; wr_wgt = DW'($urandom);
    m_act[0] = wr_act; m_wgt[0] = wr_wgt;
    run_stream("coincident", 0, 0, 1'b0, 0);
    test_completion("coincident");
  endtask

  task automatic test_random;
    for (int n = 0; n < 3; n++) begin
      load(1'b0);
      run_stream("random", int'($urandom_range(1, 10)), int'($urandom_range(1, 3)), 1'b0, 0);
      test_completion("random");
    end
  endtask

  task automatic test_k1;
    logic [7:0] da [2];
    logic [7:0] dw [2];
    logic [15:0] ea, ew;
    logic [1:0] ed;
    for (int i = 0; i < 2; i++) begin
      da[i] = 8'($urandom); dw[i] = 8'($urandom);
      k1_wr_en = 1'b1; k1_wr_addr = 1'(i); k1_wr_act = da[i]; k1_wr_wgt = dw[i];
      tick;
    end
    k1_wr_en = 1'b0; k1_start = 1'b1;
    tick;
    k1_start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick;
      ea = '0; ew = '0; ed = '0;
      for (int r = 0; r < 2; r++) begin
        if (k - r - 1 == 0) begin
          ea[r*8 +: 8] = da[r];
          ew[r*8 +: 8] = dw[r];
        end
        ed[r] = (k - r - 1 >= 1);
      end
      n_cmp++;
      if (k1_act !== ea || k1_wgt !== ew || k1_done !== ed || k1_busy !== 1'b1) begin
        n_bad++;
        $display("FAIL k1 k=%0d: act=%h wgt=%h done=%b busy=%b want %h %h %b 1",
                 k, k1_act, k1_wgt, k1_done, k1_busy, ea, ew, ed);
      end
    end
    k1_cd = 1'b1;
    #1;
    n_cmp++;
    if (k1_finish !== 1'b1) begin
      n_bad++;
      $display("FAIL k1_finish: got %b want 1", k1_finish);
    end
    tick;
    k1_cd = 1'b0;
    n_cmp++;
    if (k1_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL k1_idle: busy=%b want 0", k1_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_stall();
    test_ignored_requests();
    test_reset_mid();
    test_coincident_write();
    test_random();
    test_k1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
